// File: rtl/flag_unit.sv
// flag_unit: status-flag register, branch condition evaluator
// and LIFO flag stack for interrupt entry/exit.
`ifndef FLAGS_N
`define FLAGS_N 3
`endif
`ifndef FLAGS_Z
`define FLAGS_Z 2
`endif
`ifndef FLAGS_C
`define FLAGS_C 1
`endif
`ifndef FLAGS_V
`define FLAGS_V 0
`endif

module flag_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] AluFlags,
  input  logic       FlagsWe,
  input  logic [3:0] Cond,
  input  logic       Push,
  input  logic       Pop,
  input  logic       ErrClr,
  output logic [3:0] Flags,
  output logic       CarryOut,
  output logic       CondTrue,
  output logic       StackFull,
  output logic       StackEmpty,
  output logic       StackErr
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam logic [PW-1:0] DEPTH = PW'(STACK_DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] ptr;
  logic [3:0]    stack [2**PW];
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          err_ev;
  logic          z, n, c, v;

  assign full  = (ptr == DEPTH);
  assign empty = (ptr == '0);

  // Push and Pop together cancel each other and count as an error.
  assign push_ok = Push & ~Pop & ~full;
  assign pop_ok  = Pop & ~Push & ~empty;
  assign err_ev  = (Push & Pop)
                 | (Push & full)
                 | (Pop & empty);

  assign StackFull  = full;
  assign StackEmpty = empty;
  assign CarryOut   = Flags[`FLAGS_C];

  // Flag register: a legal pop beats a coincident ALU writeback.
  always_ff @(posedge Clock) begin
    if (Reset)
      Flags <= 4'h0;
    else if (pop_ok)
      Flags <= stack[ptr - ONE];
    else if (FlagsWe)
      Flags <= AluFlags;
  end

  // Stack pointer, saturating in both directions.
  always_ff @(posedge Clock) begin
    if (Reset)
      ptr <= '0;
    else if (push_ok)
      ptr <= ptr + ONE;
    else if (pop_ok)
      ptr <= ptr - ONE;
  end

  // Stack storage captures the pre-edge flags; no reset needed.
  always_ff @(posedge Clock) begin
    if (push_ok)
      stack[ptr] <= Flags;
  end

  // Sticky error: a new error event wins over a clear.
  always_ff @(posedge Clock) begin
    if (Reset)
      StackErr <= 1'b0;
    else if (err_ev)
      StackErr <= 1'b1;
    else if (ErrClr)
      StackErr <= 1'b0;
  end

  assign z = Flags[`FLAGS_Z];
  assign n = Flags[`FLAGS_N];
  assign c = Flags[`FLAGS_C];
  assign v = Flags[`FLAGS_V];

  // Condition evaluation uses stored flags only.
  always_comb begin
    CondTrue = 1'b0;
    unique case (Cond)
      4'h0: CondTrue = 1'b1;
      4'h1: CondTrue = z;
      4'h2: CondTrue = ~z;
      4'h3: CondTrue = c;
      4'h4: CondTrue = ~c;
      4'h5: CondTrue = n;
      4'h6: CondTrue = ~n;
      4'h7: CondTrue = v;
      4'h8: CondTrue = ~v;
      4'h9: CondTrue = c & ~z;
      4'hA: CondTrue = ~c | z;
      4'hB: CondTrue = (n == v);
      4'hC: CondTrue = (n != v);
      4'hD: CondTrue = ~z & (n == v);
      4'hE: CondTrue = z | (n != v);
      4'hF: CondTrue = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed checks of flag register,
// condition codes and flag stack.
`ifndef FLAGS_N
`define FLAGS_N 3
`endif
`ifndef FLAGS_Z
`define FLAGS_Z 2
`endif
`ifndef FLAGS_C
`define FLAGS_C 1
`endif
`ifndef FLAGS_V
`define FLAGS_V 0
`endif

module tb_flag_unit;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] AluFlags;
  logic       FlagsWe;
  logic [3:0] Cond;
  logic       Push;
  logic       Pop;
  logic       ErrClr;
  logic [3:0] Flags;
  logic       CarryOut;
  logic       CondTrue;
  logic       StackFull;
  logic       StackEmpty;
  logic       StackErr;

  int n_chk  = 0;
  int n_fail = 0;

  flag_unit #(.STACK_DEPTH(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .AluFlags   (AluFlags),
    .FlagsWe    (FlagsWe),
    .Cond       (Cond),
    .Push       (Push),
    .Pop        (Pop),
    .ErrClr     (ErrClr),
    .Flags      (Flags),
    .CarryOut   (CarryOut),
    .CondTrue   (CondTrue),
    .StackFull  (StackFull),
    .StackEmpty (StackEmpty),
    .StackErr   (StackErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Reset    = 1'b0;
    FlagsWe  = 1'b0;
    Push     = 1'b0;
    Pop      = 1'b0;
    ErrClr   = 1'b0;
  endtask

  task automatic load(input logic [3:0] f);
    idle();
    FlagsWe  = 1'b1;
    AluFlags = f;
    tick();
    FlagsWe  = 1'b0;
  endtask

  function automatic logic cond_ref(
    input logic [3:0] cc,
    input logic [3:0] f);
    logic zf, nf, cf, vf;
    zf = f[`FLAGS_Z];
    nf = f[`FLAGS_N];
    cf = f[`FLAGS_C];
    vf = f[`FLAGS_V];
    case (cc)
      4'h0: return 1'b1;
      4'h1: return zf;
      4'h2: return !zf;
      4'h3: return cf;
      4'h4: return !cf;
      4'h5: return nf;
      4'h6: return !nf;
      4'h7: return vf;
      4'h8: return !vf;
      4'h9: return cf && !zf;
      4'hA: return !cf || zf;
      4'hB: return nf == vf;
      4'hC: return nf != vf;
      4'hD: return !zf && (nf == vf);
      4'hE: return zf || (nf != vf);
      default: return 1'b0;
    endcase
  endfunction

  logic [3:0] f;
  logic [3:0] vals [4];

  initial begin
    idle();
    AluFlags = 4'h0;
    Cond     = 4'h0;
    Reset    = 1'b1;
    tick();
    tick();
    chk("rst_flags", Flags, 0);
    chk("rst_carry", CarryOut, 0);
    chk("rst_empty", StackEmpty, 1);
    chk("rst_full", StackFull, 0);
    chk("rst_err", StackErr, 0);

    // carry load and CS/CC
    f = 4'h0;
    f[`FLAGS_C] = 1'b1;
    idle();
    FlagsWe  = 1'b1;
    AluFlags = f;
    #1;
    chk("we_latency", Flags, 0);
    tick();
    FlagsWe = 1'b0;
    chk("c_flags", Flags, f);
    chk("c_carry", CarryOut, 1);
    Cond = 4'h3;
    #1;
    chk("c_cs", CondTrue, 1);
    Cond = 4'h4;
    #1;
    chk("c_cc", CondTrue, 0);

    // no bypass, carry held without FlagsWe
    AluFlags = 4'h0;
    Cond = 4'h3;
    tick();
    chk("nobypass", CondTrue, 1);
    chk("adc_hold", CarryOut, 1);

    // full condition sweep
    for (int fi = 0; fi < 16; fi++) begin
      load(4'(fi));
      for (int ci = 0; ci < 16; ci++) begin
        Cond = 4'(ci);
        #1;
        chk($sformatf("cond_%0h_f%0h", ci, fi),
            CondTrue, cond_ref(4'(ci), 4'(fi)));
      end
    end

    // fill stack with 1,2,4,8
    vals[0] = 4'h1;
    vals[1] = 4'h2;
    vals[2] = 4'h4;
    vals[3] = 4'h8;
    for (int i = 0; i < 4; i++) begin
      load(vals[i]);
      Push = 1'b1;
      tick();
      Push = 1'b0;
    end
    chk("fill_full", StackFull, 1);
    chk("fill_empty", StackEmpty, 0);
    chk("fill_err", StackErr, 0);

    // overflow
    Push = 1'b1;
    tick();
    Push = 1'b0;
    chk("ovf_err", StackErr, 1);
    chk("ovf_full", StackFull, 1);
    chk("ovf_flags", Flags, 8);

    load(4'h0);
    for (int i = 3; i >= 0; i--) begin
      Pop = 1'b1;
      tick();
      Pop = 1'b0;
      chk($sformatf("pop_%0d", i), Flags, vals[i]);
    end
    chk("pop_empty", StackEmpty, 1);
    chk("pop_full", StackFull, 0);

    // error clear and underflow
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    chk("clr_err", StackErr, 0);
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    chk("unf_err", StackErr, 1);
    chk("unf_flags", Flags, 1);
    chk("unf_empty", StackEmpty, 1);
    Pop = 1'b1;
    ErrClr = 1'b1;
    tick();
    idle();
    chk("clr_vs_unf", StackErr, 1);
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    chk("clr_again", StackErr, 0);

    // push with FlagsWe
    load(4'h5);
    Push = 1'b1;
    FlagsWe = 1'b1;
    AluFlags = 4'hA;
    tick();
    idle();
    chk("pushwe_flags", Flags, 4'hA);
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    chk("pushwe_top", Flags, 5);
    chk("pushwe_empty", StackEmpty, 1);

    // pop with FlagsWe
    load(4'h3);
    Push = 1'b1;
    tick();
    Push = 1'b0;
    Pop = 1'b1;
    FlagsWe = 1'b1;
    AluFlags = 4'hC;
    tick();
    idle();
    chk("popwe_flags", Flags, 3);
    chk("popwe_empty", StackEmpty, 1);

    // push and pop together
    load(4'h7);
    Push = 1'b1;
    tick();
    Pop = 1'b1;
    FlagsWe = 1'b1;
    AluFlags = 4'h0;
    tick();
    idle();
    chk("pp_err", StackErr, 1);
    chk("pp_flags", Flags, 0);
    chk("pp_empty", StackEmpty, 0);
    Pop = 1'b1;
    tick();
    Pop = 1'b0;
    chk("pp_top", Flags, 7);
    chk("pp_empty2", StackEmpty, 1);

    // reset mid-sequence at depth 2
    load(4'h9);
    Push = 1'b1;
    tick();
    tick();
    Push = 1'b0;
    chk("pre_rst_err", StackErr, 1);
    chk("pre_rst_empty", StackEmpty, 0);
    Reset = 1'b1;
    Push = 1'b1;
    Pop = 1'b1;
    FlagsWe = 1'b1;
    AluFlags = 4'hF;
    tick();
    idle();
    chk("mid_rst_flags", Flags, 0);
    chk("mid_rst_empty", StackEmpty, 1);
    chk("mid_rst_full", StackFull, 0);
    chk("mid_rst_err", StackErr, 0);
    chk("mid_rst_carry", CarryOut, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
